// File: rtl/rvvi_host_msg_decoder.sv
// -----------------------------------------------------------------------------
// rvvi_host_msg_decoder
//
// Purpose:
//   Parses host-to-FPGA control frames arriving on the Ethernet MAC receive
//   AXI-stream (32-bit beats, tready tied high) in the RVVI hardware tracer.
//   Each frame carries:
//     - a fixed Ethernet header (beats 0-2 and the low half of beat 3),
//     - a 6-character tag (upper half of beat 3 plus beat 4),
//     - a short payload, then padding up to the 60-byte minimum.
//   The payload is staged in shadow registers. A message commits on tlast only
//   when every required beat arrived and tuser is clear. On commit, one
//   registered strobe pulses for a single cycle together with its data.
//   Malformed, foreign, short or errored frames are dropped and counted.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   RvviAxiRdata      rx beat data, byte 0 in bits [7:0]
//   RvviAxiRstrb      rx tkeep
//   RvviAxiRvalid     beat valid (every valid beat is consumed)
//   RvviAxiRlast      last beat of frame
//   RvviAxiRuser      bad-frame flag, meaningful on the last beat
//   TriggerPulse      one-cycle strobe for TRIG
//   SlowValid/SlowData      strobe and host FIFO fill amount
//   RateValid/RateData      strobe and inter-packet delay
//   InstrValid/Minstr/InterPacketDelay  strobe, retired count and delay word
//   DropCount         saturating count of discarded frames
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rvvi_host_msg_decoder #(
  parameter int           XLEN      = 64,  // 32 or 64
  parameter logic [111:0] HDR       = 112'h005c_8f54_0000_1654_4502_1111_6843,
  parameter logic [47:0]  TAG_TRIG  = 48'h6e69_6769_7274,
  parameter logic [47:0]  TAG_SLOW  = 48'h656d_776f_6c73,
  parameter logic [47:0]  TAG_RATE  = 48'h6e69_6574_6172,
  parameter logic [47:0]  TAG_INST  = 48'h6b63_6174_736e,
  parameter logic [31:0]  RATE_INIT = 32'd2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     RvviAxiRdata,
  input  logic [3:0]      RvviAxiRstrb,
  input  logic            RvviAxiRvalid,
  input  logic            RvviAxiRlast,
  input  logic            RvviAxiRuser,
  output logic            TriggerPulse,
  output logic            SlowValid,
  output logic [31:0]     SlowData,
  output logic            RateValid,
  output logic [31:0]     RateData,
  output logic            InstrValid,
  output logic [XLEN-1:0] Minstr,
  output logic [31:0]     InterPacketDelay,
  output logic [15:0]     DropCount
);

  typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_TAIL, ST_DISCARD} state_t;
  typedef enum logic [1:0] {MSG_TRIG, MSG_SLOW, MSG_RATE, MSG_INST} msg_t;

  // INST payload: Minstr word(s) followed by the delay word.
  localparam int         DLY_SLOT   = XLEN / 32;
  localparam logic [3:0] INST_BEATS = 4'(XLEN / 32 + 1);

  state_t           state_q, state_d;
  msg_t             msg_q, msg_d;
  logic [3:0]       beat_idx_q, beat_idx_d;
  logic [15:0]      tag_lo_q, tag_lo_d;
  logic [2:0][31:0] shadow_q, shadow_d;

  logic             trig_q, trig_d;
  logic             slow_v_q, slow_v_d;
  logic [31:0]      slow_data_q, slow_data_d;
  logic             rate_v_q, rate_v_d;
  logic [31:0]      rate_data_q, rate_data_d;
  logic             inst_v_q, inst_v_d;
  logic [XLEN-1:0]  minstr_q, minstr_d;
  logic [31:0]      delay_q, delay_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  // Frame-end events produced by the next-state process.
  logic             commit;
  logic             drop;
  msg_t             commit_msg;

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  logic        full_keep;
  logic [47:0] tag_cur;
  logic        tag_known;
  msg_t        tag_msg;
  logic        hdr_ok;
  logic [3:0]  need_beats;
  logic        payload_last;
  logic [2:0]  slot_hit;

  assign full_keep = (RvviAxiRstrb == 4'hF);
  // Only meaningful on beat 4, where the current beat is the tag high half.
  assign tag_cur   = {RvviAxiRdata, tag_lo_q};

  always_comb begin
    tag_known = 1'b1;
    tag_msg   = MSG_TRIG;
    if (tag_cur == TAG_TRIG)      tag_msg = MSG_TRIG;
    else if (tag_cur == TAG_SLOW) tag_msg = MSG_SLOW;
    else if (tag_cur == TAG_RATE) tag_msg = MSG_RATE;
    else if (tag_cur == TAG_INST) tag_msg = MSG_INST;
    else                          tag_known = 1'b0;
  end

  always_comb begin
    case (beat_idx_q)
      4'd0:    hdr_ok = (RvviAxiRdata == HDR[31:0]);
      4'd1:    hdr_ok = (RvviAxiRdata == HDR[63:32]);
      4'd2:    hdr_ok = (RvviAxiRdata == HDR[95:64]);
      4'd3:    hdr_ok = (RvviAxiRdata[15:0] == HDR[111:96]);
      4'd4:    hdr_ok = tag_known;
      default: hdr_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (msg_q)
      MSG_TRIG: need_beats = 4'd0;
      MSG_SLOW: need_beats = 4'd1;
      MSG_RATE: need_beats = 4'd1;
      default:  need_beats = INST_BEATS;
    endcase
  end

  // Payload beats start at index 5; the last required one is 4 + need.
  assign payload_last = (beat_idx_q == 4'd4 + need_beats);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      assign slot_hit[gi] = (beat_idx_q == 4'(5 + gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HDR;
      msg_q      <= MSG_TRIG;
      beat_idx_q <= 4'd0;
      tag_lo_q   <= 16'd0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      beat_idx_q <= beat_idx_d;
      tag_lo_q   <= tag_lo_d;
      shadow_q   <= shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state process (also stages header/payload fields)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    beat_idx_d = beat_idx_q;
    tag_lo_d   = tag_lo_q;
    shadow_d   = shadow_q;
    commit     = 1'b0;
    drop       = 1'b0;
    commit_msg = msg_q;

    if (RvviAxiRvalid) begin
      if (RvviAxiRlast)              beat_idx_d = 4'd0;
      else if (beat_idx_q != 4'hF)   beat_idx_d = beat_idx_q + 4'd1;

      case (state_q)
        ST_HDR: begin
          if (beat_idx_q == 4'd3) tag_lo_d = RvviAxiRdata[31:16];
          if (!(full_keep && hdr_ok)) begin
            // A bad beat that also ends the frame is counted right here.
            drop    = RvviAxiRlast;
            state_d = RvviAxiRlast ? ST_HDR : ST_DISCARD;
          end else if (beat_idx_q == 4'd4) begin
            msg_d      = tag_msg;
            commit_msg = tag_msg;
            if (tag_msg == MSG_TRIG) begin
              // TRIG has no payload, so a frame ending on the tag is complete.
              if (RvviAxiRlast) begin
                commit = !RvviAxiRuser;
                drop   = RvviAxiRuser;
              end else begin
                state_d = ST_TAIL;
              end
            end else if (RvviAxiRlast) begin
              drop = 1'b1;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else if (RvviAxiRlast) begin
            drop = 1'b1;
          end
        end

        ST_PAYLOAD: begin
          if (!full_keep) begin
            drop    = RvviAxiRlast;
            state_d = RvviAxiRlast ? ST_HDR : ST_DISCARD;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (slot_hit[i]) shadow_d[i] = RvviAxiRdata;
            end
            if (payload_last) begin
              if (RvviAxiRlast) begin
                commit  = !RvviAxiRuser;
                drop    = RvviAxiRuser;
                state_d = ST_HDR;
              end else begin
                state_d = ST_TAIL;
              end
            end else if (RvviAxiRlast) begin
              drop    = 1'b1;
              state_d = ST_HDR;
            end
          end
        end

        ST_TAIL: begin
          if (RvviAxiRlast) begin
            commit  = !RvviAxiRuser;
            drop    = RvviAxiRuser;
            state_d = ST_HDR;
          end
        end

        default: begin  // ST_DISCARD
          if (RvviAxiRlast) begin
            drop    = 1'b1;
            state_d = ST_HDR;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output process
  // ---------------------------------------------------------------------------
  // shadow_d is used so a commit on the final payload beat sees that beat.
  logic [XLEN-1:0] minstr_new;
  generate
    if (XLEN == 64) begin : g_x64
      assign minstr_new = {shadow_d[1], shadow_d[0]};
    end else begin : g_x32
      assign minstr_new = shadow_d[0];
    end
  endgenerate

  always_comb begin
    trig_d      = 1'b0;
    slow_v_d    = 1'b0;
    rate_v_d    = 1'b0;
    inst_v_d    = 1'b0;
    slow_data_d = slow_data_q;
    rate_data_d = rate_data_q;
    minstr_d    = minstr_q;
    delay_d     = delay_q;
    drop_cnt_d  = drop_cnt_q;

    if (commit) begin
      case (commit_msg)
        MSG_TRIG: trig_d = 1'b1;
        MSG_SLOW: begin
          slow_v_d    = 1'b1;
          slow_data_d = shadow_d[0];
        end
        MSG_RATE: begin
          rate_v_d    = 1'b1;
          rate_data_d = shadow_d[0];
        end
        default: begin
          inst_v_d = 1'b1;
          minstr_d = minstr_new;
          delay_d  = shadow_d[DLY_SLOT];
        end
      endcase
    end

    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q      <= 1'b0;
      slow_v_q    <= 1'b0;
      slow_data_q <= 32'd0;
      rate_v_q    <= 1'b0;
      rate_data_q <= RATE_INIT;
      inst_v_q    <= 1'b0;
      minstr_q    <= '0;
      delay_q     <= 32'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      trig_q      <= trig_d;
      slow_v_q    <= slow_v_d;
      slow_data_q <= slow_data_d;
      rate_v_q    <= rate_v_d;
      rate_data_q <= rate_data_d;
      inst_v_q    <= inst_v_d;
      minstr_q    <= minstr_d;
      delay_q     <= delay_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign TriggerPulse     = trig_q;
  assign SlowValid        = slow_v_q;
  assign SlowData         = slow_data_q;
  assign RateValid        = rate_v_q;
  assign RateData         = rate_data_q;
  assign InstrValid       = inst_v_q;
  assign Minstr           = minstr_q;
  assign InterPacketDelay = delay_q;
  assign DropCount        = drop_cnt_q;

endmodule

// File: tb/tb_rvvi_host_msg_decoder.sv
`timescale 1ns/1ps

module tb_rvvi_host_msg_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rdata;
  logic [3:0]  rstrb;
  logic        rvalid;
  logic        rlast;
  logic        ruser;
  logic        TriggerPulse, SlowValid, RateValid, InstrValid;
  logic [31:0] SlowData, RateData, InterPacketDelay;
  logic [63:0] Minstr;
  logic [15:0] DropCount;

  localparam logic [47:0] T_TRIG = 48'h6e69_6769_7274;
  localparam logic [47:0] T_SLOW = 48'h656d_776f_6c73;
  localparam logic [47:0] T_RATE = 48'h6e69_6574_6172;
  localparam logic [47:0] T_INST = 48'h6b63_6174_736e;

  always #5 clk = ~clk;

  rvvi_host_msg_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .RvviAxiRdata     (rdata),
    .RvviAxiRstrb     (rstrb),
    .RvviAxiRvalid    (rvalid),
    .RvviAxiRlast     (rlast),
    .RvviAxiRuser     (ruser),
    .TriggerPulse     (TriggerPulse),
    .SlowValid        (SlowValid),
    .SlowData         (SlowData),
    .RateValid        (RateValid),
    .RateData         (RateData),
    .InstrValid       (InstrValid),
    .Minstr           (Minstr),
    .InterPacketDelay (InterPacketDelay),
    .DropCount        (DropCount)
  );

  int passed = 0;
  int total  = 0;
  int n_trig = 0, n_slow = 0, n_rate = 0, n_inst = 0, n_multi = 0;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (TriggerPulse === 1'b1) n_trig++;
    if (SlowValid === 1'b1)    n_slow++;
    if (RateValid === 1'b1)    n_rate++;
    if (InstrValid === 1'b1)   n_inst++;
    if ((int'(TriggerPulse === 1'b1) + int'(SlowValid === 1'b1) +
         int'(RateValid === 1'b1) + int'(InstrValid === 1'b1)) > 1) n_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] fw [0:31];
  logic [3:0]  fk [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic build(input logic [47:0] tag);
    for (int i = 0; i < 32; i++) begin
      fw[i] = 32'h0;
      fk[i] = 4'hF;
    end
    fw[0] = 32'h1111_6843;
    fw[1] = 32'h1654_4502;
    fw[2] = 32'h8f54_0000;
    fw[3] = {tag[15:0], 16'h005c};
    fw[4] = tag[47:16];
  endtask

  task automatic idle();
    rvalid = 1'b0;
    rlast  = 1'b0;
    ruser  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rvalid = 1'b0;
    rlast  = 1'b0;
    ruser  = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sends fw[0..n-1], tlast on the final beat; leaves the bus on that beat.
  task automatic send_frame(input int n, input bit user, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = int'($urandom_range(0, 3));
        for (int k = 0; k < g; k++) begin
          rvalid = 1'b0;
          rdata  = $urandom;
          rlast  = 1'($urandom_range(0, 1));
          ruser  = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      rvalid = 1'b1;
      rdata  = fw[i];
      rstrb  = fk[i];
      rlast  = (i == n - 1);
      ruser  = (i == n - 1) ? user : 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    rvalid = 1'b0;
    rdata  = 32'h0;
    rstrb  = 4'hF;
    rlast  = 1'b0;
    ruser  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_strobes", {60'd0, TriggerPulse, SlowValid, RateValid, InstrValid}, 64'd0);
    chk("rst_slowdata", SlowData, 64'd0);
    chk("rst_ratedata", RateData, 64'd2);
    chk("rst_minstr", Minstr, 64'd0);
    chk("rst_delay", InterPacketDelay, 64'd0);
    chk("rst_drop", DropCount, 64'd0);

    // TRIG frame, 15 beats
    build(T_TRIG);
    send_frame(15, 1'b0, 1'b0);
    chk("trig_pulse", TriggerPulse, 64'd1);
    chk("trig_others", {61'd0, SlowValid, RateValid, InstrValid}, 64'd0);
    chk("trig_ratedata", RateData, 64'd2);
    chk("trig_drop", DropCount, 64'd0);
    idle();
    chk("trig_one_cycle", TriggerPulse, 64'd0);

    // RATE frame
    build(T_RATE);
    fw[5] = 32'h0000_0010;
    send_frame(15, 1'b0, 1'b0);
    chk("rate_valid", RateValid, 64'd1);
    chk("rate_data", RateData, 64'h10);
    idle();
    chk("rate_one_cycle", RateValid, 64'd0);
    chk("rate_hold", RateData, 64'h10);
    do_reset();
    chk("rate_after_reset", RateData, 64'd2);

    // Reset in the middle of a frame, then a full SLOW frame
    build(T_SLOW);
    fw[5] = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = fw[i]; rstrb = 4'hF; rlast = 1'b0; ruser = 1'b0;
      @(posedge clk); #1;
    end
    do_reset();
    send_frame(15, 1'b0, 1'b0);
    chk("midrst_slow_valid", SlowValid, 64'd1);
    chk("midrst_slow_data", SlowData, 64'h77);
    chk("midrst_drop", DropCount, 64'd0);
    idle();

    // INST frame
    build(T_INST);
    fw[5] = 32'h0000_0005;
    fw[6] = 32'h0000_0001;
    fw[7] = 32'h0000_0003;
    send_frame(15, 1'b0, 1'b0);
    chk("inst_valid", InstrValid, 64'd1);
    chk("inst_minstr", Minstr, 64'h1_0000_0005);
    chk("inst_delay", InterPacketDelay, 64'd3);
    idle();

    // Header mismatch, then a valid SLOW frame back-to-back
    build(T_SLOW);
    fw[1] = 32'h1654_4503;
    fw[5] = 32'h0000_0999;
    send_frame(15, 1'b0, 1'b0);
    chk("badhdr_no_strobe", SlowValid, 64'd0);
    chk("badhdr_drop", DropCount, 64'd1);
    build(T_SLOW);
    fw[5] = 32'h0000_0200;
    send_frame(15, 1'b0, 1'b0);
    chk("b2b_slow_valid", SlowValid, 64'd1);
    chk("b2b_slow_data", SlowData, 64'h200);
    chk("b2b_drop", DropCount, 64'd1);
    idle();

    // Short INST frame: tlast on the payload low word
    build(T_INST);
    fw[5] = 32'h0000_0009;
    send_frame(6, 1'b0, 1'b0);
    chk("short_no_strobe", InstrValid, 64'd0);
    chk("short_drop", DropCount, 64'd2);
    chk("short_minstr", Minstr, 64'h1_0000_0005);
    idle();

    // RATE frame with tuser on tlast
    build(T_RATE);
    fw[5] = 32'h0000_0044;
    send_frame(15, 1'b1, 1'b0);
    chk("tuser_no_strobe", RateValid, 64'd0);
    chk("tuser_drop", DropCount, 64'd3);
    chk("tuser_ratedata", RateData, 64'd2);
    idle();

    // RATE frame with random valid gaps
    build(T_RATE);
    fw[5] = 32'h0000_0033;
    send_frame(15, 1'b0, 1'b1);
    chk("gaps_valid", RateValid, 64'd1);
    chk("gaps_data", RateData, 64'h33);
    chk("gaps_drop", DropCount, 64'd3);
    idle();

    // Partial tkeep on a payload beat
    build(T_SLOW);
    fw[5] = 32'h0000_0555;
    fk[5] = 4'h7;
    send_frame(15, 1'b0, 1'b0);
    chk("keep_no_strobe", SlowValid, 64'd0);
    chk("keep_drop", DropCount, 64'd4);
    chk("keep_slowdata", SlowData, 64'h200);
    idle();

    // Unknown tag
    build(48'h6b63_6174_736f);
    fw[5] = 32'h1;
    fw[6] = 32'h2;
    fw[7] = 32'h3;
    send_frame(15, 1'b0, 1'b0);
    chk("tag_no_strobe", InstrValid, 64'd0);
    chk("tag_drop", DropCount, 64'd5);
    idle();

    // Strobe totals over the directed frames
    chk("cnt_trig", n_trig, 64'd1);
    chk("cnt_slow", n_slow, 64'd2);
    chk("cnt_rate", n_rate, 64'd2);
    chk("cnt_inst", n_inst, 64'd1);
    chk("cnt_multi", n_multi, 64'd0);

    // Saturation: back-to-back one-beat frames are all short
    do_reset();
    rvalid = 1'b1;
    rdata  = 32'h1111_6843;
    rstrb  = 4'hF;
    rlast  = 1'b1;
    ruser  = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", DropCount, 64'hFFFF);
    @(posedge clk); #1;
    chk("sat_hold", DropCount, 64'hFFFF);
    idle();
    chk("sat_no_strobe", {60'd0, TriggerPulse, SlowValid, RateValid, InstrValid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
